control_reg: RTL and testbench



---
 rtl/rv32i_pkg.sv | 16 +
 rtl/register_file.sv | 39 +++
 rtl/control_reg.sv | 87 ++++++++
 tb/tb_control_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width and the base opcode map.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two combinational read ports, one
// synchronous write port. x0 is hardwired to zero on the read side and
// never written.
module register_file
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            writeEnable,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] reg_write,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] reg1,
  output logic [XLEN-1:0] reg2
);

  logic [XLEN-1:0] regs [32];

  // Reset clears the whole array and wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable && (rd != 5'd0)) begin
      regs[rd] <= reg_write;
    end
  end

  // Reads are unbypassed: a register written this cycle shows its old value.
  always_comb begin
    reg1 = '0;
    reg2 = '0;
    if (rs1 != 5'd0) reg1 = regs[rs1];
    if (rs2 != 5'd0) reg2 = regs[rs2];
  end

endmodule

// File: rtl/control_reg.sv
// Instruction decoder, immediate generator and register file for the
// single-cycle RV32I datapath. Everything except the register writes is
// combinational from the instruction word.
module control_reg
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] reg_write,
  input  logic            writeEnable,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] immediate,
  output logic            ALU_source,
  output logic            memToReg,
  output logic            load_pc,
  output logic [XLEN-1:0] reg1,
  output logic [XLEN-1:0] reg2
);

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign rd     = instruction[11:7];

  // Immediate assembly per instruction format; R-type and unknown give 0.
  // Shift-immediates use the plain I-type field, funct7 resolves SRLI/SRAI.
  always_comb begin
    immediate = '0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        immediate = {{20{instruction[31]}}, instruction[31:20]};
      OP_STORE:
        immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:
        immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        immediate = {instruction[31:12], 12'b0};
      OP_JAL:
        immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
      default:
        immediate = '0;
    endcase
  end

  // Datapath steering flags; everything not listed leaves all three low.
  always_comb begin
    ALU_source = 1'b0;
    memToReg   = 1'b0;
    load_pc    = 1'b0;
    case (opcode)
      OP_IMM, OP_STORE, OP_LUI, OP_AUIPC: ALU_source = 1'b1;
      OP_LOAD: begin
        ALU_source = 1'b1;
        memToReg   = 1'b1;
      end
      OP_JALR: begin
        ALU_source = 1'b1;
        load_pc    = 1'b1;
      end
      OP_JAL: load_pc = 1'b1;
      default: ;
    endcase
  end

  register_file u_register_file (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (writeEnable),
    .rd          (rd),
    .reg_write   (reg_write),
    .rs1         (rs1),
    .rs2         (rs2),
    .reg1        (reg1),
    .reg2        (reg2)
  );

endmodule

// File: tb/tb_control_reg.sv
// Self-checking bench for control_reg: directed cases from the RV32I
// encoding rules followed by randomized instruction/write traffic checked
// against an arithmetic immediate model and an array register model.
module tb_control_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] reg_write;
  logic        writeEnable;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] immediate;
  logic        ALU_source;
  logic        memToReg;
  logic        load_pc;
  logic [31:0] reg1;
  logic [31:0] reg2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

  control_reg dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .reg_write   (reg_write),
    .writeEnable (writeEnable),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .immediate   (immediate),
    .ALU_source  (ALU_source),
    .memToReg    (memToReg),
    .load_pc     (load_pc),
    .reg1        (reg1),
    .reg2        (reg2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value computed with plain arithmetic (mod 2^32) from the
  // format definitions: sign bit contributes a negative weight.
  function automatic logic [31:0] exp_imm(input logic [31:0] u);
    logic [31:0] s;
    logic [31:0] op;
    s  = u >> 31;
    op = u & 32'h7F;
    case (op)
      32'h13, 32'h03, 32'h67:
        return ((u >> 20) & 32'h7FF) - s * 32'd2048;
      32'h23:
        return ((u >> 25) & 32'h3F) * 32'd32 + ((u >> 7) & 32'h1F) - s * 32'd2048;
      32'h63:
        return ((u >> 7) & 32'h1) * 32'd2048 + ((u >> 25) & 32'h3F) * 32'd32
             + ((u >> 8) & 32'hF) * 32'd2 - s * 32'd4096;
      32'h37, 32'h17:
        return (u >> 12) * 32'd4096;
      32'h6F:
        return ((u >> 12) & 32'hFF) * 32'd4096 + ((u >> 20) & 32'h1) * 32'd2048
             + ((u >> 21) & 32'h3FF) * 32'd2 - s * 32'd1048576;
      default:
        return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] exp_flags(input logic [6:0] op);
    logic a, m, p;
    a = op inside {7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17};
    m = (op == 7'h03);
    p = op inside {7'h6F, 7'h67};
    return {a, m, p};
  endfunction

  task automatic chk_decode(input string tag);
    logic [31:0] u;
    u = instruction;
    chk({tag, ".opcode"}, {25'd0, opcode}, u & 32'h7F);
    chk({tag, ".funct3"}, {29'd0, funct3}, (u >> 12) & 32'h7);
    chk({tag, ".funct7"}, {25'd0, funct7}, u >> 25);
    chk({tag, ".rs1"},    {27'd0, rs1},    (u >> 15) & 32'h1F);
    chk({tag, ".rs2"},    {27'd0, rs2},    (u >> 20) & 32'h1F);
    chk({tag, ".rd"},     {27'd0, rd},     (u >> 7) & 32'h1F);
    chk({tag, ".imm"},    immediate,       exp_imm(u));
    chk({tag, ".flags"},  {29'd0, ALU_source, memToReg, load_pc},
        {29'd0, exp_flags(u[6:0])});
  endtask

  task automatic chk_reads(input string tag);
    logic [31:0] u;
    u = instruction;
    chk({tag, ".reg1"}, reg1, model[(u >> 15) & 32'h1F]);
    chk({tag, ".reg2"}, reg2, model[(u >> 20) & 32'h1F]);
  endtask

  // Advance one rising edge and apply its effect to the reference model.
  task automatic edge_step();
    logic [31:0] dst;
    dst = (instruction >> 7) & 32'h1F;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (writeEnable && dst != 0) begin
      model[dst] = reg_write;
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
            7'h0F, 7'h73, 7'h7F};

    rst = 1'b1; instruction = 32'd0; reg_write = 32'd0; writeEnable = 1'b0;
    edge_step();
    rst = 1'b0;

    // ADD x3, x2, x1
    instruction = 32'h001101B3; settle();
    chk("add.rs1", {27'd0, rs1}, 32'd2);
    chk("add.rs2", {27'd0, rs2}, 32'd1);
    chk("add.rd",  {27'd0, rd},  32'd3);
    chk("add.opcode", {25'd0, opcode}, 32'h33);
    chk("add.funct7", {25'd0, funct7}, 32'd0);
    chk("add.imm", immediate, 32'd0);
    chk("add.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'd0);
    chk_reads("add.reset");

    // SUB x31, x20, x11
    instruction = 32'h40BA0FB3; settle();
    chk("sub.rs1", {27'd0, rs1}, 32'd20);
    chk("sub.rs2", {27'd0, rs2}, 32'd11);
    chk("sub.rd",  {27'd0, rd},  32'd31);
    chk("sub.funct7", {25'd0, funct7}, 32'h20);

    // Write 0xDEADBEEF into x5; old value visible until the edge.
    instruction = (32'd5 << 7) | (32'd5 << 15) | 32'h33;
    reg_write = 32'hDEADBEEF; writeEnable = 1'b1; settle();
    chk("wr5.before", reg1, 32'd0);
    edge_step();
    writeEnable = 1'b0;
    instruction = (32'd5 << 15) | (32'd5 << 20) | 32'h33; settle();
    chk("wr5.reg1", reg1, 32'hDEADBEEF);
    chk("wr5.reg2", reg2, 32'hDEADBEEF);

    // Write to x0 is discarded.
    instruction = 32'h33; reg_write = 32'h12345678; writeEnable = 1'b1;
    edge_step();
    writeEnable = 1'b0; settle();
    chk("wr0.reg1", reg1, 32'd0);

    // Reset with writeEnable held high to x7: reset wins.
    instruction = (32'd7 << 7) | 32'h33; reg_write = 32'hA5A5A5A5;
    writeEnable = 1'b1; rst = 1'b1;
    edge_step();
    rst = 1'b0; writeEnable = 1'b0;
    for (int a = 0; a < 32; a++) begin
      instruction = (32'(a) << 15) | (32'(31 - a) << 20) | 32'h33; settle();
      chk($sformatf("rst.reg1[%0d]", a), reg1, 32'd0);
      chk($sformatf("rst.reg2[%0d]", 31 - a), reg2, 32'd0);
    end

    instruction = 32'hFFF00093; settle();
    chk("addi.imm", immediate, 32'hFFFFFFFF);
    chk("addi.alusrc", {31'd0, ALU_source}, 32'd1);
    instruction = 32'h00812283; settle();
    chk("lw.imm", immediate, 32'd8);
    chk("lw.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'b110);
    instruction = 32'hFE112E23; settle();
    chk("sw.imm", immediate, 32'hFFFFFFFC);
    chk("sw.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'b100);
    instruction = 32'h0080006F; settle();
    chk("jal.imm", immediate, 32'd8);
    chk("jal.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'b001);
    instruction = 32'hFE000EE3; settle();
    chk("beq.imm", immediate, 32'hFFFFFFFC);
    chk("beq.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'd0);
    instruction = 32'h123452B7; settle();
    chk("lui.imm", immediate, 32'h12345000);
    chk("lui.flags", {29'd0, ALU_source, memToReg, load_pc}, 32'b100);

    // Randomized traffic; register indices kept small half the time so
    // reads frequently hit recently written entries.
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end
      instruction = ins;
      reg_write   = $urandom;
      writeEnable = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 39) == 0);
      settle();
      chk_decode($sformatf("rnd%0d", n));
      chk_reads($sformatf("rnd%0d", n));
      edge_step();
      settle();
      chk_reads($sformatf("rnd%0d.post", n));
    end
    rst = 1'b0; writeEnable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
